stack_seq: RTL and testbench

STACK_SEQ -- requirements
Module: stack_seq

---
 rtl/stack_pkg.sv | 39 +++
 rtl/stack_seq_if.sv | 40 ++++
 rtl/stack_seq.sv | 152 +++++++++++++++
 tb/tb_stack_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stack_pkg : shared op/state encodings and bounds helper for stack_seq
// Rev 1.0
// ----------------------------------------------------------------------------
package stack_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_XCHG = 2'd2,
    OP_ILL  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // An op is rejected when it is illegal or would under/overflow the stack.
  function automatic logic op_rejected(input op_e op, input word_t depth, input word_t max_depth);
    logic rej;
    case (op)
      OP_PUSH: rej = (depth == max_depth);
      OP_POP:  rej = (depth == '0);
      OP_XCHG: rej = (depth == '0);
      default: rej = 1'b1;
    endcase
    return rej;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stack_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stack_seq_if : request/response handshake bundle for stack_seq
// Rev 1.0
// ----------------------------------------------------------------------------
interface stack_seq_if;

  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_op;
  stack_pkg::word_t    req_data;
  logic                rsp_valid;
  logic                rsp_ready;
  stack_pkg::word_t    rsp_data;
  logic                rsp_err;

  modport master (
    output req_valid,
    output req_op,
    output req_data,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_data,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/stack_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stack_seq : sequences PUSH/POP/XCHG requests into strobes for a stack memory
//             stage and returns one response per accepted request.
// Rev 1.0
// ----------------------------------------------------------------------------
module stack_seq
  import stack_pkg::*;
#(
  parameter logic [15:0] MAX_DEPTH = 16'd32767
) (
  input  logic        clk,
  input  logic        rst,
  stack_seq_if.slave  bus,
  output logic        push,
  output logic        pop,
  output logic        swap,
  output logic [15:0] pushorswap_data,
  input  logic [15:0] mem_out,
  output logic [15:0] depth
);

  state_e state_q, state_d;
  op_e    op_q,    op_d;
  word_t  depth_q, depth_d;
  word_t  wdata_q, wdata_d;
  word_t  rsp_data_q, rsp_data_d;
  logic   push_q, push_d;
  logic   pop_q,  pop_d;
  logic   swap_q, swap_d;
  logic   rsp_valid_q, rsp_valid_d;
  logic   rsp_err_q,   rsp_err_d;

  op_e    req_op_w;
  logic   accept_w;

  assign req_op_w = op_e'(bus.req_op);
  assign accept_w = bus.req_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    depth_d     = depth_q;
    wdata_d     = '0;
    push_d      = 1'b0;
    pop_d       = 1'b0;
    swap_d      = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_w) begin
          op_d = req_op_w;
          if (op_rejected(req_op_w, depth_q, MAX_DEPTH)) begin
            // Rejected ops answer straight away and never touch the memory stage.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d = ST_ISSUE;
            push_d  = (req_op_w == OP_PUSH);
            pop_d   = (req_op_w == OP_POP);
            swap_d  = (req_op_w == OP_XCHG);
            wdata_d = (req_op_w == OP_POP) ? '0 : bus.req_data;
          end
        end
      end

      ST_ISSUE: begin
        case (op_q)
          OP_PUSH: begin
            depth_d     = depth_q + 16'd1;
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = '0;
          end
          OP_POP: begin
            depth_d = depth_q - 16'd1;
            state_d = ST_CAPTURE;
          end
          default: begin
            state_d = ST_CAPTURE;
          end
        endcase
      end

      ST_CAPTURE: begin
        // Memory stage presents the popped/old-top word during this cycle.
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = mem_out;
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_PUSH;
      depth_q     <= '0;
      wdata_q     <= '0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      swap_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      depth_q     <= depth_d;
      wdata_q     <= wdata_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      swap_q      <= swap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;

  assign push            = push_q;
  assign pop             = pop_q;
  assign swap            = swap_q;
  assign pushorswap_data = wdata_q;
  assign depth           = depth_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_stack_seq : directed + random checks of stack_seq against a queue model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_stack_seq;

  localparam logic [15:0] DEPTH_MAX = 16'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push, pop, swap;
  logic [15:0] pushorswap_data;
  logic [15:0] mem_out;
  logic [15:0] depth;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] ref_stk[$];
  logic [15:0] mem_stk[$];

  stack_seq_if sif ();

  stack_seq #(.MAX_DEPTH(DEPTH_MAX)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (sif),
    .push            (push),
    .pop             (pop),
    .swap            (swap),
    .pushorswap_data (pushorswap_data),
    .mem_out         (mem_out),
    .depth           (depth)
  );

  always #5 clk = ~clk;

  // Memory stage: an independent stack that answers one cycle after a strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_stk.delete();
      mem_out <= 16'h0000;
    end else begin
      if (push) mem_stk.push_back(pushorswap_data);
      if (pop) begin
        if (mem_stk.size() > 0) mem_out <= mem_stk.pop_back();
        else                    mem_out <= 16'hDEAD;
      end
      if (swap) begin
        if (mem_stk.size() > 0) begin
          mem_out <= mem_stk[mem_stk.size()-1];
          void'(mem_stk.pop_back());
          mem_stk.push_back(pushorswap_data);
        end else begin
          mem_out <= 16'hDEAD;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE (called just after a negedge) and follow it to IDLE again.
  task automatic run_op(input logic [1:0] op, input logic [15:0] data, input int hold, input string tag);
    logic        err;
    logic [15:0] exp_data;
    logic [15:0] exp_wdata;
    logic [2:0]  exp_strb;
    int          lat;
    int          d0;
    err       = 1'b0;
    exp_data  = 16'h0000;
    exp_wdata = 16'h0000;
    exp_strb  = 3'b000;
    d0        = ref_stk.size();
    case (op)
      2'd0: if (ref_stk.size() >= int'(DEPTH_MAX)) err = 1'b1;
            else begin ref_stk.push_back(data); exp_strb = 3'b100; exp_wdata = data; end
      2'd1: if (ref_stk.size() == 0) err = 1'b1;
            else begin exp_data = ref_stk.pop_back(); exp_strb = 3'b010; end
      2'd2: if (ref_stk.size() == 0) err = 1'b1;
            else begin
              exp_data = ref_stk[ref_stk.size()-1];
              void'(ref_stk.pop_back());
              ref_stk.push_back(data);
              exp_strb  = 3'b001;
              exp_wdata = data;
            end
      default: err = 1'b1;
    endcase
    lat = err ? 1 : ((op == 2'd0) ? 2 : 3);

    check({tag, ".ready_idle"}, 32'(sif.req_ready), 32'd1);
    sif.req_valid = 1'b1;
    sif.req_op    = op;
    sif.req_data  = data;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      check({tag, ".strobes"}, 32'({push, pop, swap}), 32'((n == 1) ? exp_strb : 3'b000));
      if (n == 1) begin
        check({tag, ".wdata"}, 32'(pushorswap_data), 32'(exp_wdata));
        check({tag, ".depth_pre"}, 32'(depth), 32'(d0));
      end
      check({tag, ".rsp_valid"}, 32'(sif.rsp_valid), 32'(n == lat));
      check({tag, ".ready_busy"}, 32'(sif.req_ready), 32'd0);
      sif.req_valid = 1'($urandom_range(0, 1));
      sif.req_op    = 2'($urandom);
      sif.req_data  = 16'($urandom);
    end
    check({tag, ".rsp_err"}, 32'(sif.rsp_err), 32'(err));
    check({tag, ".rsp_data"}, 32'(sif.rsp_data), 32'(exp_data));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(sif.rsp_valid), 32'd1);
      check({tag, ".hold_data"}, 32'(sif.rsp_data), 32'(exp_data));
      check({tag, ".hold_err"}, 32'(sif.rsp_err), 32'(err));
      check({tag, ".hold_ready"}, 32'(sif.req_ready), 32'd0);
      check({tag, ".hold_strb"}, 32'({push, pop, swap}), 32'd0);
      sif.req_valid = 1'($urandom_range(0, 1));
      sif.req_op    = 2'($urandom);
    end
    sif.rsp_ready = 1'b1;
    sif.req_valid = 1'b0;
    @(negedge clk);
    sif.rsp_ready = 1'b0;
    check({tag, ".done_valid"}, 32'(sif.rsp_valid), 32'd0);
    check({tag, ".done_ready"}, 32'(sif.req_ready), 32'd1);
    check({tag, ".depth_post"}, 32'(depth), 32'(ref_stk.size()));
  endtask

  initial begin
    sif.req_valid = 1'b0;
    sif.req_op    = 2'd0;
    sif.req_data  = 16'h0000;
    sif.rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst.strobes", 32'({push, pop, swap}), 32'd0);
    check("rst.wdata", 32'(pushorswap_data), 32'd0);
    check("rst.rsp_valid", 32'(sif.rsp_valid), 32'd0);
    check("rst.rsp_data", 32'(sif.rsp_data), 32'd0);
    check("rst.rsp_err", 32'(sif.rsp_err), 32'd0);
    check("rst.depth", 32'(depth), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst.ready", 32'(sif.req_ready), 32'd1);

    run_op(2'd0, 16'h1234, 0, "push1234");
    run_op(2'd1, 16'h0000, 0, "pop1234");
    run_op(2'd1, 16'h0000, 1, "pop_empty");
    run_op(2'd2, 16'h7777, 0, "xchg_empty");
    run_op(2'd0, 16'hABCD, 0, "pushABCD");
    run_op(2'd1, 16'h0000, 0, "popABCD");
    run_op(2'd0, 16'h1111, 0, "push1111");
    run_op(2'd2, 16'h2222, 0, "xchg2222");
    run_op(2'd3, 16'h3333, 0, "illegal");
    run_op(2'd0, 16'h5555, 5, "hold5");
    for (int i = 0; i < 3; i++) run_op(2'd0, 16'(16'h0A00 + i), 0, "fill");
    run_op(2'd0, 16'hBEEF, 0, "overflow");
    run_op(2'd2, 16'hC0DE, 0, "xchg_full");
    for (int i = 0; i < 4; i++) run_op(2'd1, 16'h0000, 0, "drain");
    run_op(2'd1, 16'h0000, 0, "underflow");

    for (int i = 0; i < 150; i++)
      run_op(2'($urandom_range(0, 3)), 16'($urandom), $urandom_range(0, 2), "rand");

    if (ref_stk.size() == 0) run_op(2'd0, 16'h4242, 0, "pre_abort");
    sif.req_valid = 1'b1;
    sif.req_op    = 2'd1;
    @(negedge clk);
    sif.req_valid = 1'b0;
    check("abort.issue_pop", 32'(pop), 32'd1);
    @(negedge clk);
    check("abort.capture_strb", 32'({push, pop, swap}), 32'd0);
    check("abort.capture_valid", 32'(sif.rsp_valid), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("abort.strobes", 32'({push, pop, swap}), 32'd0);
    check("abort.wdata", 32'(pushorswap_data), 32'd0);
    check("abort.rsp_valid", 32'(sif.rsp_valid), 32'd0);
    check("abort.rsp_data", 32'(sif.rsp_data), 32'd0);
    check("abort.rsp_err", 32'(sif.rsp_err), 32'd0);
    check("abort.depth", 32'(depth), 32'd0);
    ref_stk.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort.after_strb", 32'({push, pop, swap}), 32'd0);
    check("abort.after_valid", 32'(sif.rsp_valid), 32'd0);
    run_op(2'd0, 16'h9876, 0, "push_after_abort");
    run_op(2'd1, 16'h0000, 0, "pop_after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
